multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Multi-cycle control sequencer that consumes the 3-bit opcode set defined in Definitions: ADD, XOR, OR, LOD, STR, BGZ, SLL, AND.
- Captures 9-bit instructions and walks each one through FETCH/DECODE/EXEC/MEM/WB.
- Drives the datapath enables and holds a request/acknowledge handshake with data memory.
- Sits between instruction memory and the datapath: register file, ALU, PC.

Parameters:
HALT_WORD, 9'h1FF, instruction encoding that stops execution
MEM_TIMEOUT, 8, max MEM-state cycles waiting for MemAck before entering ERROR (>=1)
CNT_W, 16, width of the retired-instruction counter

Ports:
Clk  input  1  clock, all state updates on rising edge
Reset_n  input  1  asynchronous active-low reset
Start  input  1  level; begins execution from IDLE
Instr  input  9  instruction word from instruction memory; opcode is [8:6]
GtZero  input  1  datapath flag: selected register > 0 (signed)
MemAck  input  1  data-memory completion for the current request
IrLoad  output  1  load instruction register
AluOp  output  3  Definitions opcode driven to the ALU
RegWrEn  output  1  register-file write enable
MemRd  output  1  data-memory read request
MemWr  output  1  data-memory write request
PcEn  output  1  advance or load PC
BranchTaken  output  1  PC loads the branch target instead of PC+1
Done  output  1  halted
Error  output  1  memory timeout occurred, sticky
RetireCnt  output  CNT_W  instructions retired

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERROR.
- Reset_n low (any time, including mid-MEM): state=IDLE, IR=0, timeout counter=0, RetireCnt=0, Error=0. All outputs are 0 while in IDLE.
- Control outputs are combinational decodes of the registered state and IR. No output depends combinationally on MemAck or GtZero except where listed below.
- IDLE: Start=1 -> FETCH.
- FETCH: IrLoad=1; IR <= Instr at the edge; -> DECODE.
- DECODE: AluOp=IR[8:6]. IR==HALT_WORD -> HALT, else -> EXEC.
- EXEC: AluOp=IR[8:6].
  - ADD/XOR/OR/SLL/AND: RegWrEn=1, PcEn=1, retire; -> FETCH.
  - BGZ: PcEn=1, BranchTaken=GtZero (combinational in EXEC only), retire; -> FETCH.
  - LOD/STR: AluOp=kADD (address computation); -> MEM; timeout counter cleared to 0.
- MEM: MemRd=1 for LOD, MemWr=1 for STR. Request is held constant until MemAck.
  - MemAck=1 with LOD: -> WB.
  - MemAck=1 with STR: PcEn=1, retire; -> FETCH.
  - MemAck=0: counter increments. When counter reaches MEM_TIMEOUT-1 with no ack -> ERROR. MEM therefore lasts at most MEM_TIMEOUT cycles.
  - MemAck in the final allowed cycle wins over timeout.
- WB: RegWrEn=1, PcEn=1, retire; -> FETCH.
- HALT: Done=1; remains until Start=0, then -> IDLE. HALT_WORD is not counted as retired.
- ERROR: Error=1, all other outputs 0; remains until reset.
- Retire: RetireCnt increments by 1 on the edge leaving a retiring state; wraps 2^CNT_W-1 -> 0.
- Latencies, FETCH to next FETCH:
  - ALU/BGZ: 3 cycles.
  - STR: 4 + wait cycles.
  - LOD: 5 + wait cycles.
- MemAck outside MEM is ignored.
- Start is ignored outside IDLE and HALT.

Test Plan:
- Reset, then Start=1, Instr=9'b000_001_010 (ADD) -> IrLoad in cycle 1, AluOp=000 in cycles 2-3, RegWrEn=PcEn=1 in cycle 3 only, RetireCnt=1, back in FETCH in cycle 4.
- BGZ (9'b101_xxxxxx) with GtZero=1, then again with GtZero=0 -> first: BranchTaken=1 and PcEn=1 in EXEC; second: BranchTaken=0 and PcEn=1; RetireCnt=2.
- LOD with MemAck after 3 wait cycles -> MemRd high for 4 MEM cycles, then WB with RegWrEn=1; total 8 cycles; STR with MemAck in first MEM cycle -> MemWr 1 cycle, PcEn same cycle, RegWrEn never asserted.
- STR with MemAck held 0, MEM_TIMEOUT=8 -> MemWr high exactly 8 cycles, then Error=1 sticky; MemAck=1 afterwards changes nothing; Reset_n low clears Error and RetireCnt.
- Instr=9'h1FF after two ADDs -> Done=1, RetireCnt=2; Start held 1 keeps HALT; Start=0 -> IDLE next cycle; Start=1 restarts.
- Reset_n asserted asynchronously mid-MEM (between edges) -> MemRd drops immediately, state IDLE; preload RetireCnt path to 16'hFFFF and retire once -> 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer
module multicycle_ctrl #(
    parameter logic [8:0] HALT_WORD   = 9'h1FF,
    parameter int         MEM_TIMEOUT = 8,
    parameter int         CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [8:0]       Instr,
    input  logic             GtZero,
    input  logic             MemAck,
    output logic             IrLoad,
    output logic [2:0]       AluOp,
    output logic             RegWrEn,
    output logic             MemRd,
    output logic             MemWr,
    output logic             PcEn,
    output logic             BranchTaken,
    output logic             Done,
    output logic             Error,
    output logic [CNT_W-1:0] RetireCnt
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_LOD = 3'd3;
    localparam logic [2:0] OP_STR = 3'd4;
    localparam logic [2:0] OP_BGZ = 3'd5;

    // Counter only has to reach MEM_TIMEOUT-1; keep at least one bit for MEM_TIMEOUT=1.
    localparam int         TW       = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_ERROR
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [8:0]        r_ir;
    logic [TW-1:0]     r_tmo;
    logic [CNT_W-1:0]  r_retire_cnt;

    logic              w_retire;
    logic              w_tmo_clr;
    logic              w_tmo_inc;
    logic [2:0]        w_op;
    logic              w_is_lod;
    logic              w_is_str;

    assign w_op      = r_ir[8:6];
    assign w_is_lod  = (w_op == OP_LOD);
    assign w_is_str  = (w_op == OP_STR);
    assign RetireCnt = r_retire_cnt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= S_IDLE;
            r_ir         <= '0;
            r_tmo        <= '0;
            r_retire_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (IrLoad) begin
                r_ir <= Instr;
            end
            if (w_tmo_clr) begin
                r_tmo <= '0;
            end else if (w_tmo_inc) begin
                r_tmo <= r_tmo + TW'(1);
            end
            if (w_retire) begin
                r_retire_cnt <= r_retire_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_retire    = 1'b0;
        w_tmo_clr   = 1'b0;
        w_tmo_inc   = 1'b0;
        IrLoad      = 1'b0;
        AluOp       = 3'd0;
        RegWrEn     = 1'b0;
        MemRd       = 1'b0;
        MemWr       = 1'b0;
        PcEn        = 1'b0;
        BranchTaken = 1'b0;
        Done        = 1'b0;
        Error       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                IrLoad = 1'b1;
                w_next = S_DECODE;
            end
            S_DECODE: begin
                AluOp  = w_op;
                w_next = (r_ir == HALT_WORD) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                if (w_is_lod || w_is_str) begin
                    // Address is base + offset, so the ALU adds regardless of opcode.
                    AluOp     = OP_ADD;
                    w_tmo_clr = 1'b1;
                    w_next    = S_MEM;
                end else begin
                    AluOp    = w_op;
                    PcEn     = 1'b1;
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                    if (w_op == OP_BGZ) begin
                        BranchTaken = GtZero;
                    end else begin
                        RegWrEn = 1'b1;
                    end
                end
            end
            S_MEM: begin
                MemRd = w_is_lod;
                MemWr = w_is_str;
                // An ack in the last allowed cycle is checked before the timeout.
                if (MemAck) begin
                    if (w_is_lod) begin
                        w_next = S_WB;
                    end else begin
                        PcEn     = 1'b1;
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end
                end else if (r_tmo == TMO_LAST) begin
                    w_next = S_ERROR;
                end else begin
                    w_tmo_inc = 1'b1;
                end
            end
            S_WB: begin
                RegWrEn  = 1'b1;
                PcEn     = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_HALT: begin
                Done = 1'b1;
                if (!Start) begin
                    w_next = S_IDLE;
                end
            end
            S_ERROR: begin
                Error = 1'b1;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

    localparam int         MEM_TO = 8;
    localparam logic [8:0] HALT   = 9'h1FF;

    localparam logic [10:0] B_IRL = 11'h400;
    localparam logic [10:0] B_RWE = 11'h040;
    localparam logic [10:0] B_MRD = 11'h020;
    localparam logic [10:0] B_MWR = 11'h010;
    localparam logic [10:0] B_PCE = 11'h008;
    localparam logic [10:0] B_BT  = 11'h004;
    localparam logic [10:0] B_DN  = 11'h002;
    localparam logic [10:0] B_ER  = 11'h001;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Start;
    logic [8:0]  Instr;
    logic        GtZero;
    logic        MemAck;
    logic        IrLoad, RegWrEn, MemRd, MemWr, PcEn, BranchTaken, Done, Error;
    logic [2:0]  AluOp;
    logic [15:0] RetireCnt;
    logic        s_irl, s_rwe, s_mrd, s_mwr, s_pce, s_bt, s_dn, s_er;
    logic [2:0]  s_aop;
    logic [3:0]  s_cnt;
    logic [10:0] dut_vec;

    int n_checks = 0;
    int n_errors = 0;
    int exp_retired = 0;

    assign dut_vec = {IrLoad, AluOp, RegWrEn, MemRd, MemWr, PcEn, BranchTaken, Done, Error};

    multicycle_ctrl #(.HALT_WORD(HALT), .MEM_TIMEOUT(MEM_TO), .CNT_W(16)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Instr(Instr), .GtZero(GtZero),
        .MemAck(MemAck), .IrLoad(IrLoad), .AluOp(AluOp), .RegWrEn(RegWrEn), .MemRd(MemRd),
        .MemWr(MemWr), .PcEn(PcEn), .BranchTaken(BranchTaken), .Done(Done), .Error(Error),
        .RetireCnt(RetireCnt)
    );

    // Narrow-counter twin sharing all inputs, so wrap-around is reached quickly.
    multicycle_ctrl #(.HALT_WORD(HALT), .MEM_TIMEOUT(MEM_TO), .CNT_W(4)) dut_s (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Instr(Instr), .GtZero(GtZero),
        .MemAck(MemAck), .IrLoad(s_irl), .AluOp(s_aop), .RegWrEn(s_rwe), .MemRd(s_mrd),
        .MemWr(s_mwr), .PcEn(s_pce), .BranchTaken(s_bt), .Done(s_dn), .Error(s_er),
        .RetireCnt(s_cnt)
    );

    initial forever #5 Clk = ~Clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] aop(input logic [2:0] o);
        return {1'b0, o, 7'b0};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_cycle(input string tag, input logic [10:0] exp);
        #1;
        check_val(tag, 32'(dut_vec), 32'(exp));
        check_val({tag, "_cnt"}, 32'(RetireCnt), exp_retired & 32'hFFFF);
        check_val({tag, "_cnt4"}, 32'(s_cnt), exp_retired & 32'hF);
    endtask

    task automatic assert_reset();
        Reset_n = 1'b0;
        exp_retired = 0;
        check_cycle("reset", 11'd0);
    endtask

    task automatic release_reset();
        Start = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        tick();
    endtask

    task automatic do_start();
        Start = 1'b1;
        check_cycle("idle_start", 11'd0);
        tick();
    endtask

    task automatic do_halt(input int hold);
        for (int i = 0; i < hold; i++) begin
            Start = 1'b1;
            check_cycle("halt_hold", B_DN);
            tick();
        end
        Start = 1'b0;
        check_cycle("halt_exit", B_DN);
        tick();
        check_cycle("idle_after_halt", 11'd0);
        tick();
    endtask

    task automatic check_error(input int n);
        for (int i = 0; i < n; i++) begin
            MemAck = 1'($urandom);
            Start  = 1'($urandom);
            GtZero = 1'($urandom);
            Instr  = 9'($urandom);
            check_cycle("error_sticky", B_ER);
            tick();
        end
    endtask

    // Walks one instruction from its FETCH cycle. outcome: 0 next FETCH, 1 HALT, 2 ERROR, 3 reset mid-MEM.
    task automatic run_instr(input logic [8:0] instr, input int waits, input bit gtz,
                             input int rst_at, output int outcome);
        logic [2:0] op;
        bit         lod;
        bit         ack;
        op  = instr[8:6];
        lod = (op == 3'd3);
        outcome = 0;
        Instr  = instr;
        MemAck = 1'($urandom);
        GtZero = 1'($urandom);
        Start  = 1'($urandom);
        check_cycle("fetch", B_IRL);
        tick();
        Instr  = 9'($urandom);
        MemAck = 1'($urandom);
        check_cycle("decode", aop(op));
        tick();
        if (instr == HALT) begin
            outcome = 1;
            return;
        end
        GtZero = gtz;
        MemAck = 1'($urandom);
        if (op == 3'd3 || op == 3'd4) begin
            check_cycle("exec_mem", aop(3'd0));
            tick();
        end else if (op == 3'd5) begin
            check_cycle("exec_bgz", aop(op) | B_PCE | (gtz ? B_BT : 11'd0));
            tick();
            exp_retired++;
            return;
        end else begin
            check_cycle("exec_alu", aop(op) | B_RWE | B_PCE);
            tick();
            exp_retired++;
            return;
        end
        ack = 1'b0;
        for (int i = 0; i < MEM_TO && !ack; i++) begin
            ack    = (i == waits);
            MemAck = ack;
            GtZero = 1'($urandom);
            check_cycle("mem", (lod ? B_MRD : B_MWR) | ((!lod && ack) ? B_PCE : 11'd0));
            if (i == rst_at) begin
                Reset_n = 1'b0;
                exp_retired = 0;
                check_cycle("mem_async_reset", 11'd0);
                outcome = 3;
                return;
            end
            tick();
        end
        if (!ack) begin
            outcome = 2;
            return;
        end
        if (!lod) begin
            exp_retired++;
            return;
        end
        MemAck = 1'($urandom);
        check_cycle("wb", B_RWE | B_PCE);
        tick();
        exp_retired++;
    endtask

    initial begin
        int oc;
        int r;
        int waits;
        logic [8:0] ins;
        Reset_n = 1'b0;
        Start   = 1'b0;
        Instr   = 9'd0;
        GtZero  = 1'b0;
        MemAck  = 1'b0;
        #3;
        check_cycle("por", 11'd0);
        release_reset();
        check_cycle("idle", 11'd0);
        tick();

        do_start();
        run_instr(9'b000_001_010, 0, 1'b0, -1, oc);
        run_instr(9'b101_000_011, 0, 1'b1, -1, oc);
        run_instr(9'b101_110_001, 0, 1'b0, -1, oc);
        run_instr(9'b011_001_000, 3, 1'b0, -1, oc);
        run_instr(9'b100_010_001, 0, 1'b0, -1, oc);
        run_instr(9'b011_100_111, MEM_TO - 1, 1'b0, -1, oc);
        run_instr(9'b100_011_010, 99, 1'b0, -1, oc);
        check_val("timeout_outcome", 32'(oc), 32'd2);
        check_error(4);
        assert_reset();
        release_reset();

        do_start();
        run_instr(9'b000_001_010, 0, 1'b0, -1, oc);
        run_instr(9'b111_010_011, 0, 1'b0, -1, oc);
        run_instr(HALT, 0, 1'b0, -1, oc);
        check_val("halt_outcome", 32'(oc), 32'd1);
        do_halt(3);
        do_start();
        run_instr(9'b110_001_001, 0, 1'b0, -1, oc);
        run_instr(9'b011_000_101, 5, 1'b0, 2, oc);
        check_val("mem_reset_outcome", 32'(oc), 32'd3);
        release_reset();

        do_start();
        for (int n = 0; n < 250; n++) begin
            r = int'($urandom_range(0, 99));
            ins = (r < 4) ? HALT : 9'($urandom);
            waits = (r >= 97) ? MEM_TO + 2 : int'($urandom_range(0, 4));
            run_instr(ins, waits, 1'($urandom), -1, oc);
            if (oc == 1) begin
                do_halt(int'($urandom_range(0, 2)));
                do_start();
            end else if (oc == 2) begin
                check_error(2);
                assert_reset();
                release_reset();
                do_start();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
